fetch_predict_unit: RTL and testbench

FETCH_PREDICT_UNIT -- requirements
Module: fetch_predict_unit

---
 rtl/fetch_predict_unit_pkg.sv | 34 +++
 rtl/fetch_predict_unit_btb_table.sv | 69 ++++++
 rtl/fetch_predict_unit.sv | 94 +++++++++
 tb/tb_fetch_predict_unit.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_predict_unit_pkg.sv
// Shared definitions for the fetch/predict slice: counter encodings, defaults
// and BTB geometry helpers.
package fetch_predict_unit_pkg;

  localparam int          DEFAULT_XLEN     = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  function automatic int idxWidth(input int entries);
    return $clog2(entries);
  endfunction

  function automatic int tagWidth(input int xlen, input int entries);
    return xlen - $clog2(entries) - 2;
  endfunction

  // Two-bit saturating step toward the resolved direction.
  function automatic logic [1:0] ctrNext(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    if (taken) begin
      if (ctr == ST) res = ST;
      else           res = ctr + 2'd1;
    end else begin
      if (ctr == SNT) res = SNT;
      else            res = ctr - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/fetch_predict_unit_btb_table.sv
// Direct-mapped BTB storage: one combinational read port and one synchronous
// read-modify-write training port.
import fetch_predict_unit_pkg::*;

module btb_table #(
  parameter int DEPTH = 16,
  parameter int IW    = 4,
  parameter int TW    = 26,
  parameter int XLEN  = 32
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic [IW-1:0]   RdIdx,
  output logic            RdValid,
  output logic [TW-1:0]   RdTag,
  output logic [XLEN-1:0] RdTarget,
  output logic [1:0]      RdCtr,
  input  logic            WrEn,
  input  logic [IW-1:0]   WrIdx,
  input  logic [TW-1:0]   WrTag,
  input  logic            WrTaken,
  input  logic [XLEN-1:0] WrTarget
);

  logic            valid_r  [DEPTH];
  logic [1:0]      ctr_r    [DEPTH];
  logic [TW-1:0]   tag_r    [DEPTH];
  logic [XLEN-1:0] target_r [DEPTH];
  logic            wrHit_s;

  // Read port returns pre-update contents; no write-through bypass.
  always_comb begin
    RdValid  = valid_r[RdIdx];
    RdTag    = tag_r[RdIdx];
    RdTarget = target_r[RdIdx];
    RdCtr    = ctr_r[RdIdx];
  end

  // Whether the training branch already owns its slot.
  always_comb begin
    wrHit_s = valid_r[WrIdx] && (tag_r[WrIdx] == WrTag);
  end

  // Valid bits and counters: cleared on reset, trained on resolve.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_r[i] <= 1'b0;
        ctr_r[i]   <= WNT;
      end
    end else if (WrEn) begin
      if (wrHit_s) begin
        ctr_r[WrIdx] <= ctrNext(ctr_r[WrIdx], WrTaken);
      end else if (WrTaken) begin
        valid_r[WrIdx] <= 1'b1;
        ctr_r[WrIdx]   <= WT;
      end
    end
  end

  // Tag and target need no reset; a taken resolve (hit or allocate) rewrites both.
  always_ff @(posedge Clk) begin
    if (!Reset && WrEn && WrTaken) begin
      tag_r[WrIdx]    <= WrTag;
      target_r[WrIdx] <= WrTarget;
    end
  end

endmodule

// File: rtl/fetch_predict_unit.sv
// Fetch PC register with BTB-driven next-PC selection and branch statistics.
import fetch_predict_unit_pkg::*;

module fetch_predict_unit #(
  parameter int              XLEN        = DEFAULT_XLEN,
  parameter int              BTB_ENTRIES = 16,
  parameter logic [XLEN-1:0] RESET_PC    = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            StallF,
  input  logic            RedirectE,
  input  logic [XLEN-1:0] RedirectPCE,
  input  logic            UpdateE,
  input  logic [XLEN-1:0] UpdatePCE,
  input  logic            UpdateTakenE,
  input  logic [XLEN-1:0] UpdateTargetE,
  output logic [XLEN-1:0] PCF,
  output logic [XLEN-1:0] PCPlus4F,
  output logic            PredTakenF,
  output logic [XLEN-1:0] PredTargetF,
  output logic [31:0]     BranchCount,
  output logic [31:0]     MispredCount
);

  localparam int IW = idxWidth(BTB_ENTRIES);
  localparam int TW = tagWidth(XLEN, BTB_ENTRIES);

  logic [XLEN-1:0] pc_r;
  logic [31:0]     branchCount_r;
  logic [31:0]     mispredCount_r;
  logic            rdValid_s;
  logic [TW-1:0]   rdTag_s;
  logic [XLEN-1:0] rdTarget_s;
  logic [1:0]      rdCtr_s;
  logic            predTaken_s;
  logic [XLEN-1:0] pcPlus4_s;
  logic [XLEN-1:0] predTarget_s;

  btb_table #(
    .DEPTH (BTB_ENTRIES),
    .IW    (IW),
    .TW    (TW),
    .XLEN  (XLEN)
  ) uBtb (
    .Clk      (Clk),
    .Reset    (Reset),
    .RdIdx    (pc_r[IW+1:2]),
    .RdValid  (rdValid_s),
    .RdTag    (rdTag_s),
    .RdTarget (rdTarget_s),
    .RdCtr    (rdCtr_s),
    .WrEn     (UpdateE),
    .WrIdx    (UpdatePCE[IW+1:2]),
    .WrTag    (UpdatePCE[XLEN-1:IW+2]),
    .WrTaken  (UpdateTakenE),
    .WrTarget (UpdateTargetE)
  );

  // Lookup on the current fetch PC; the +4 wraps naturally at the top of memory.
  always_comb begin
    pcPlus4_s   = pc_r + XLEN'(3'd4);
    predTaken_s = rdValid_s && (rdTag_s == pc_r[XLEN-1:IW+2]) && rdCtr_s[1];
    if (predTaken_s) predTarget_s = rdTarget_s;
    else             predTarget_s = pcPlus4_s;
  end

  // Fetch PC: redirect beats stall, otherwise follow the prediction.
  always_ff @(posedge Clk) begin
    if (Reset)          pc_r <= RESET_PC;
    else if (RedirectE) pc_r <= RedirectPCE;
    else if (StallF)    pc_r <= pc_r;
    else                pc_r <= predTarget_s;
  end

  // Resolved-branch and mispredict statistics, wrapping modulo 2^32.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      branchCount_r  <= 32'd0;
      mispredCount_r <= 32'd0;
    end else begin
      if (UpdateE)   branchCount_r  <= branchCount_r + 32'd1;
      if (RedirectE) mispredCount_r <= mispredCount_r + 32'd1;
    end
  end

  assign PCF          = pc_r;
  assign PCPlus4F     = pcPlus4_s;
  assign PredTakenF   = predTaken_s;
  assign PredTargetF  = predTarget_s;
  assign BranchCount  = branchCount_r;
  assign MispredCount = mispredCount_r;

endmodule

// File: tb/tb_fetch_predict_unit.sv
// Self-checking bench: directed vector table, hand-written corner sequences and
// randomized traffic against a behavioural BTB model.
module tb_fetch_predict_unit;

  logic        Clk = 1'b0;
  logic        Reset, StallF, RedirectE, UpdateE, UpdateTakenE;
  logic [31:0] RedirectPCE, UpdatePCE, UpdateTargetE;
  logic [31:0] PCF, PCPlus4F, PredTargetF, BranchCount, MispredCount;
  logic        PredTakenF;

  int tests = 0;
  int fails = 0;

  fetch_predict_unit #(.XLEN(32), .BTB_ENTRIES(16), .RESET_PC(32'h0)) dut (
    .Clk(Clk), .Reset(Reset), .StallF(StallF), .RedirectE(RedirectE),
    .RedirectPCE(RedirectPCE), .UpdateE(UpdateE), .UpdatePCE(UpdatePCE),
    .UpdateTakenE(UpdateTakenE), .UpdateTargetE(UpdateTargetE),
    .PCF(PCF), .PCPlus4F(PCPlus4F), .PredTakenF(PredTakenF),
    .PredTargetF(PredTargetF), .BranchCount(BranchCount), .MispredCount(MispredCount)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic stall, input logic redir, input logic [31:0] rpc,
                       input logic upd, input logic taken, input logic [31:0] upc, input logic [31:0] utgt);
    Reset = rst; StallF = stall; RedirectE = redir; RedirectPCE = rpc;
    UpdateE = upd; UpdateTakenE = taken; UpdatePCE = upc; UpdateTargetE = utgt;
  endtask

  // One clock with the given inputs; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic rst, input logic stall, input logic redir, input logic [31:0] rpc,
                      input logic upd, input logic taken, input logic [31:0] upc, input logic [31:0] utgt);
    @(negedge Clk);
    drive(rst, stall, redir, rpc, upd, taken, upc, utgt);
    @(posedge Clk);
    #1;
  endtask

  task automatic checkFetch(input string tag, input logic [31:0] pc, input logic pt, input logic [31:0] tgt);
    chk({tag, ".PCF"}, PCF, pc);
    chk({tag, ".PredTakenF"}, {31'd0, PredTakenF}, {31'd0, pt});
    chk({tag, ".PredTargetF"}, PredTargetF, tgt);
  endtask

  typedef struct {
    logic        stall, redir;
    logic [31:0] redirPc;
    logic        upd, taken;
    logic [31:0] updPc, updTgt;
    logic [31:0] expPc;
    logic        expTaken;
    logic [31:0] expTgt, expBr, expMis;
  } vec_t;

  vec_t vecs[9];

  // Behavioural model: a 16-slot direct-mapped table of whole-PC tags and confidences.
  bit          mValid[16];
  int unsigned mTag[16];
  logic [31:0] mTgt[16];
  int          mConf[16];
  logic [31:0] mPc;
  logic [31:0] mBr, mMis;

  function automatic int slotOf(input logic [31:0] pc);
    return int'((pc >> 2) % 32'd16);
  endfunction

  function automatic bit mPredTaken(input logic [31:0] pc);
    int s = slotOf(pc);
    return mValid[s] && (mTag[s] == (pc >> 6)) && (mConf[s] >= 2);
  endfunction

  function automatic logic [31:0] mPredTarget(input logic [31:0] pc);
    if (mPredTaken(pc)) return mTgt[slotOf(pc)];
    return pc + 32'd4;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 16; i++) begin mValid[i] = 1'b0; mConf[i] = 1; end
    mPc = 32'h0; mBr = 32'd0; mMis = 32'd0;
  endtask

  task automatic modelClock(input logic rst, input logic stall, input logic redir, input logic [31:0] rpc,
                            input logic upd, input logic taken, input logic [31:0] upc, input logic [31:0] utgt);
    logic [31:0] nxt;
    int s;
    bit hit;
    if (rst) begin
      modelReset();
      return;
    end
    if (redir)      nxt = rpc;
    else if (stall) nxt = mPc;
    else            nxt = mPredTarget(mPc);
    if (upd) begin
      s = slotOf(upc);
      hit = mValid[s] && (mTag[s] == (upc >> 6));
      if (hit) begin
        if (taken) begin
          mConf[s] = (mConf[s] == 3) ? 3 : mConf[s] + 1;
          mTgt[s] = utgt;
        end else begin
          mConf[s] = (mConf[s] == 0) ? 0 : mConf[s] - 1;
        end
      end else if (taken) begin
        mValid[s] = 1'b1; mTag[s] = upc >> 6; mTgt[s] = utgt; mConf[s] = 2;
      end
      mBr = mBr + 32'd1;
    end
    if (redir) mMis = mMis + 32'd1;
    mPc = nxt;
  endtask

  // Small address pool so random traffic aliases, hits and wraps.
  function automatic logic [31:0] poolPc();
    logic [31:0] tg;
    logic [31:0] ix;
    tg = 32'($urandom_range(0, 3));
    if ($urandom_range(0, 7) == 0) tg = 32'h03FF_FFFF;
    ix = 32'($urandom_range(0, 3));
    return (tg << 6) | (ix << 2);
  endfunction

  initial begin
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Reset state.
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkFetch("reset", 32'h0, 1'b0, 32'h4);
    chk("reset.BranchCount", BranchCount, 32'd0);
    chk("reset.MispredCount", MispredCount, 32'd0);

    //            stall redir rpc           upd   tkn   updPc         updTgt        expPc         pt    expTgt        br     mis
    vecs[0] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        32'h4,        1'b0, 32'h8,        32'd0, 32'd0};
    vecs[1] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        32'h8,        1'b0, 32'hC,        32'd0, 32'd0};
    vecs[2] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h40,       32'h100,      32'hC,        1'b0, 32'h10,       32'd1, 32'd0};
    vecs[3] = '{1'b0, 1'b1, 32'h40,       1'b0, 1'b0, 32'h0,        32'h0,        32'h40,       1'b1, 32'h100,      32'd1, 32'd1};
    vecs[4] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        32'h100,      1'b0, 32'h104,      32'd1, 32'd1};
    vecs[5] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h40,       32'h100,      32'h100,      1'b0, 32'h104,      32'd2, 32'd1};
    vecs[6] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h40,       32'h0,        32'h100,      1'b0, 32'h104,      32'd3, 32'd1};
    vecs[7] = '{1'b0, 1'b1, 32'h40,       1'b1, 1'b0, 32'h40,       32'h0,        32'h40,       1'b0, 32'h44,       32'd4, 32'd2};
    vecs[8] = '{1'b1, 1'b1, 32'h200,      1'b0, 1'b0, 32'h0,        32'h0,        32'h200,      1'b0, 32'h204,      32'd4, 32'd3};

    for (int i = 0; i < 9; i++) begin
      step(1'b0, vecs[i].stall, vecs[i].redir, vecs[i].redirPc,
           vecs[i].upd, vecs[i].taken, vecs[i].updPc, vecs[i].updTgt);
      checkFetch($sformatf("vec%0d", i), vecs[i].expPc, vecs[i].expTaken, vecs[i].expTgt);
      chk($sformatf("vec%0d.BranchCount", i), BranchCount, vecs[i].expBr);
      chk($sformatf("vec%0d.MispredCount", i), MispredCount, vecs[i].expMis);
    end

    // Aliasing: 0x80 evicts 0x40 from slot 0 and starts weakly taken.
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h40, 32'h100);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h80, 32'h300);
    step(1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0);
    checkFetch("alias.old", 32'h40, 1'b0, 32'h44);
    step(1'b0, 1'b0, 1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 32'h0);
    checkFetch("alias.new", 32'h80, 1'b1, 32'h300);
    // Same-cycle update to the looked-up slot: lookup still shows old state, edge applies it.
    @(negedge Clk);
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h80, 32'h0);
    #1;
    chk("nobypass.PredTakenF", {31'd0, PredTakenF}, 32'd1);
    @(posedge Clk); #1;
    checkFetch("alias.weak", 32'h80, 1'b0, 32'h84);

    // Reset wins over concurrent update and redirect, and discards training.
    step(1'b1, 1'b1, 1'b1, 32'h500, 1'b1, 1'b1, 32'h0, 32'h600);
    checkFetch("midreset", 32'h0, 1'b0, 32'h4);
    chk("midreset.BranchCount", BranchCount, 32'd0);
    chk("midreset.MispredCount", MispredCount, 32'd0);
    step(1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0);
    checkFetch("midreset.miss40", 32'h40, 1'b0, 32'h44);
    step(1'b0, 1'b0, 1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 32'h0);
    checkFetch("midreset.miss80", 32'h80, 1'b0, 32'h84);

    // Wrap at the top of the address space.
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("wrap.PCPlus4F", PCPlus4F, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("wrap.PCF", PCF, 32'h0);

    // Randomized traffic against the model.
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    modelReset();
    for (int c = 0; c < 3000; c++) begin
      logic rst, stall, redir, upd, taken;
      logic [31:0] rpc, upc, utgt;
      @(negedge Clk);
      chk("rnd.PCF", PCF, mPc);
      chk("rnd.PCPlus4F", PCPlus4F, mPc + 32'd4);
      chk("rnd.PredTakenF", {31'd0, PredTakenF}, {31'd0, mPredTaken(mPc)});
      chk("rnd.PredTargetF", PredTargetF, mPredTarget(mPc));
      chk("rnd.BranchCount", BranchCount, mBr);
      chk("rnd.MispredCount", MispredCount, mMis);
      rst   = ($urandom_range(0, 199) == 0);
      stall = ($urandom_range(0, 3) == 0);
      redir = ($urandom_range(0, 7) == 0);
      upd   = ($urandom_range(0, 9) < 4);
      taken = ($urandom_range(0, 2) != 0);
      rpc   = poolPc();
      upc   = poolPc();
      utgt  = poolPc();
      drive(rst, stall, redir, rpc, upd, taken, upc, utgt);
      modelClock(rst, stall, redir, rpc, upd, taken, upc, utgt);
    end
    @(negedge Clk);
    chk("rnd.final.PCF", PCF, mPc);
    chk("rnd.final.BranchCount", BranchCount, mBr);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
